// File: rtl/adder_axi_sequencer_if.sv
// AXI4-Lite bundle between the adder sequencer (master) and the adder register slave.
interface adder_axi_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/adder_axi_sequencer.sv
// AXI4-Lite master running one add operation: write A, write B, read sum, read overflow.
// Define ADDSEQ_TIMEOUT_EN to abort any transaction stalled for TIMEOUT_CYCLES cycles.
module adder_axi_sequencer #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_sum,
  output logic                  res_ovf,
  output logic                  res_err,
  output logic                  res_timeout,
  adder_axi_sequencer_if.master m_axi
);

  typedef enum logic [2:0] {StIdle, StWrite, StWresp, StRead, StRdata, StDone} state_e;

  state_e                state_q, state_d;
  logic                  step_q, step_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;

  logic aw_pend, w_pend, aw_hs, w_hs;

`ifdef ADDSEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic            busy;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Each write channel valid is held only until its own handshake.
  assign aw_pend = (state_q == StWrite) && !aw_done_q;
  assign w_pend  = (state_q == StWrite) && !w_done_q;
  assign aw_hs   = aw_pend && m_axi.awready;
  assign w_hs    = w_pend && m_axi.wready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      step_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef ADDSEQ_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef ADDSEQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef ADDSEQ_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          a_d       = req_a;
          b_d       = req_b;
          sum_d     = '0;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
          step_d    = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef ADDSEQ_TIMEOUT_EN
          tmo_d     = 1'b0;
`endif
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWresp;
        end
      end
      StWresp: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != 2'b00) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (!step_q) begin
            step_d  = 1'b1;
            state_d = StWrite;
          end else begin
            step_d  = 1'b0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (m_axi.arready) state_d = StRdata;
      end
      StRdata: begin
        if (m_axi.rvalid) begin
          if (m_axi.rresp != 2'b00) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (!step_q) begin
            sum_d   = m_axi.rdata;
            step_d  = 1'b1;
            state_d = StRead;
          end else begin
            ovf_d   = m_axi.rdata[0];
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef ADDSEQ_TIMEOUT_EN
    busy  = (state_q == StWrite) || (state_q == StWresp) ||
            (state_q == StRead)  || (state_q == StRdata);
    cnt_d = '0;
    if (busy && (state_d == state_q)) begin
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        // Stalled for the full budget in one state: abandon the operation.
        state_d   = StDone;
        err_d     = 1'b1;
        tmo_d     = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
`endif
  end

  always_comb begin
    req_ready     = (state_q == StIdle);
    res_valid     = (state_q == StDone);
    res_sum       = sum_q;
    res_ovf       = ovf_q;
    res_err       = err_q;
`ifdef ADDSEQ_TIMEOUT_EN
    res_timeout   = tmo_q;
`else
    res_timeout   = 1'b0;
`endif

    m_axi.awvalid = aw_pend;
    m_axi.wvalid  = w_pend;
    m_axi.wstrb   = '1;
    m_axi.awaddr  = '0;
    m_axi.wdata   = '0;
    if (state_q == StWrite) begin
      m_axi.awaddr = step_q ? (BASE_ADDR + ADDR_WIDTH'(4)) : BASE_ADDR;
      m_axi.wdata  = step_q ? b_q : a_q;
    end
    m_axi.bready  = (state_q == StWresp);

    m_axi.arvalid = (state_q == StRead);
    m_axi.araddr  = '0;
    if (state_q == StRead) begin
      m_axi.araddr = step_q ? (BASE_ADDR + ADDR_WIDTH'(12)) : (BASE_ADDR + ADDR_WIDTH'(8));
    end
    m_axi.rready  = (state_q == StRdata);
  end

endmodule

// File: tb/tb_adder_axi_sequencer.sv
// Directed bench for adder_axi_sequencer against a small AXI4-Lite adder slave model.
module tb_adder_axi_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, res_valid, res_ready;
  logic [31:0] req_a, req_b, res_sum;
  logic        res_ovf, res_err, res_timeout;

  adder_axi_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  adder_axi_sequencer #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (8),
    .BASE_ADDR     (8'h00),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_ovf    (res_ovf),
    .res_err    (res_err),
    .res_timeout(res_timeout),
    .m_axi      (bus.master)
  );

  always #5 clk = ~clk;

  // Slave model configuration
  logic [7:0] cfg_aw_delay = 8'd0;
  logic [7:0] cfg_w_delay  = 8'd0;
  logic       cfg_ar_stall = 1'b0;
  logic [1:0] cfg_bresp    = 2'b00;
  logic [1:0] cfg_rresp    = 2'b00;

  // Slave model state
  logic [7:0]  aw_wait, w_wait, aw_addr_q;
  logic        aw_got, w_got;
  logic [31:0] w_data_q, reg_a, reg_b;
  logic        s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [7:0]  aw_log [128];
  logic [31:0] w_log  [128];
  logic [7:0]  ar_log [128];
  int aw_n = 0, w_n = 0, ar_n = 0, awv_n = 0, wv_n = 0, arv_n = 0, bad_strb = 0;

  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [32:0] full_sum;

  assign bus.awready = (aw_wait == cfg_aw_delay);
  assign bus.wready  = (w_wait == cfg_w_delay);
  assign bus.arready = !cfg_ar_stall;
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.rvalid  = s_rvalid;
  assign bus.rresp   = s_rresp;
  assign bus.rdata   = s_rdata;

  assign aw_hs    = bus.awvalid && bus.awready;
  assign w_hs     = bus.wvalid && bus.wready;
  assign ar_hs    = bus.arvalid && bus.arready;
  assign wr_fire  = (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_addr  = aw_hs ? bus.awaddr : aw_addr_q;
  assign wr_data  = w_hs ? bus.wdata : w_data_q;
  assign full_sum = {1'b0, reg_a} + {1'b0, reg_b};

  always @(posedge clk) begin
    if (bus.awvalid) awv_n <= awv_n + 1;
    if (bus.wvalid)  wv_n  <= wv_n + 1;
    if (bus.arvalid) arv_n <= arv_n + 1;
    if (aw_hs) begin aw_log[aw_n[6:0]] <= bus.awaddr; aw_n <= aw_n + 1; end
    if (w_hs) begin
      w_log[w_n[6:0]] <= bus.wdata;
      w_n <= w_n + 1;
      if (bus.wstrb != 4'hF) bad_strb <= bad_strb + 1;
    end
    if (ar_hs) begin ar_log[ar_n[6:0]] <= bus.araddr; ar_n <= ar_n + 1; end

    if (!rstn) begin
      aw_wait  <= 8'd0;
      w_wait   <= 8'd0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_bresp  <= 2'b00;
      s_rresp  <= 2'b00;
      s_rdata  <= 32'd0;
    end else begin
      if (aw_hs) aw_wait <= 8'd0;
      else if (bus.awvalid) aw_wait <= aw_wait + 8'd1;
      if (w_hs) w_wait <= 8'd0;
      else if (bus.wvalid) w_wait <= w_wait + 8'd1;

      if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
      if (wr_fire) begin
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= cfg_bresp;
        if (wr_addr == 8'h00) reg_a <= wr_data;
        else if (wr_addr == 8'h04) reg_b <= wr_data;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= bus.awaddr; end
        if (w_hs) begin w_got <= 1'b1; w_data_q <= bus.wdata; end
      end

      if (s_rvalid && bus.rready) s_rvalid <= 1'b0;
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rresp  <= cfg_rresp;
        s_rdata  <= (bus.araddr == 8'h08) ? full_sum[31:0] : {31'd0, full_sum[32]};
      end
    end
  end

  int total = 0;
  int bad = 0;
  int aw0, w0, ar0, awv0, wv0, arv0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    aw0 = aw_n; w0 = w_n; ar0 = ar_n; awv0 = awv_n; wv0 = wv_n; arv0 = arv_n;
  endtask

  // Starts #1 after a rising edge; returns with the block idle again.
  task automatic run_op(input logic [31:0] a, b, input int hold, output int lat,
                        output logic [31:0] sum, output logic ovf, err, tmo);
    int cyc;
    req_a = a; req_b = b; req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("req_ready_wait", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
    chk("res_valid_wait", res_valid, 1'b1);
    lat = cyc; sum = res_sum; ovf = res_ovf; err = res_err; tmo = res_timeout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_sum", res_sum, sum);
      chk("hold_err", res_err, err);
    end
    chk("no_bypass", req_ready, 1'b0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_after", req_ready, 1'b1);
    chk("valid_after", res_valid, 1'b0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat, cyc;
    logic [31:0] s;
    logic        o, e, t;

    vecs[0] = '{a: 32'd5,          b: 32'd7,          sum: 32'd12,         ovf: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          sum: 32'd0,          ovf: 1'b1};
    vecs[2] = '{a: 32'h1234_5678,  b: 32'h1111_1111,  sum: 32'h2345_6789,  ovf: 1'b0};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  sum: 32'd0,          ovf: 1'b1};
    vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  sum: 32'hFFFF_FFFE,  ovf: 1'b1};
    vecs[5] = '{a: 32'h7FFF_FFFF,  b: 32'd1,          sum: 32'h8000_0000,  ovf: 1'b0};

    rstn = 1'b0; req_valid = 1'b0; res_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b000);
    chk("rst_readies", {bus.bready, bus.rready}, 2'b00);
    chk("rst_addr", {bus.awaddr, bus.araddr}, 16'h0000);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_res", {res_sum, res_ovf, res_err, res_timeout}, 35'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Always-ready slave over the vector table
    for (int v = 0; v < 6; v++) begin
      snap();
      run_op(vecs[v].a, vecs[v].b, 0, lat, s, o, e, t);
      chk("latency", lat, 9);
      chk("sum", s, vecs[v].sum);
      chk("ovf", o, vecs[v].ovf);
      chk("err", e, 1'b0);
      chk("timeout", t, 1'b0);
      chk("aw_beats", aw_n - aw0, 2);
      chk("w_beats", w_n - w0, 2);
      chk("ar_beats", ar_n - ar0, 2);
      chk("awaddr0", aw_log[aw0 % 128], 8'h00);
      chk("awaddr1", aw_log[(aw0 + 1) % 128], 8'h04);
      chk("wdata0", w_log[w0 % 128], vecs[v].a);
      chk("wdata1", w_log[(w0 + 1) % 128], vecs[v].b);
      chk("araddr0", ar_log[ar0 % 128], 8'h08);
      chk("araddr1", ar_log[(ar0 + 1) % 128], 8'h0C);
    end

    // awready delayed 3 cycles, wready immediate
    cfg_aw_delay = 8'd3;
    snap();
    run_op(32'h10, 32'h20, 0, lat, s, o, e, t);
    chk("awdly_latency", lat, 15);
    chk("awdly_sum", s, 32'h30);
    chk("awdly_awv_cycles", awv_n - awv0, 8);
    chk("awdly_wv_cycles", wv_n - wv0, 2);
    chk("awdly_aw_beats", aw_n - aw0, 2);
    chk("awdly_w_beats", w_n - w0, 2);
    chk("awdly_wdata0", w_log[w0 % 128], 32'h10);
    cfg_aw_delay = 8'd0;

    // wready delayed 2 cycles, awready immediate
    cfg_w_delay = 8'd2;
    snap();
    run_op(32'd100, 32'd23, 0, lat, s, o, e, t);
    chk("wdly_latency", lat, 13);
    chk("wdly_sum", s, 32'd123);
    chk("wdly_awv_cycles", awv_n - awv0, 2);
    chk("wdly_wv_cycles", wv_n - wv0, 6);
    cfg_w_delay = 8'd0;

    // SLVERR on first write: abort, outputs stable while res_ready held low
    cfg_bresp = 2'b10;
    snap();
    run_op(32'd9, 32'd9, 5, lat, s, o, e, t);
    chk("berr_err", e, 1'b1);
    chk("berr_sum", s, 32'd0);
    chk("berr_ovf", o, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("berr_aw_beats", aw_n - aw0, 1);
    chk("berr_w_beats", w_n - w0, 1);
    chk("berr_ar_beats", ar_n - ar0, 0);
    cfg_bresp = 2'b00;

    // SLVERR on the sum read
    cfg_rresp = 2'b10;
    snap();
    run_op(32'd3, 32'd4, 0, lat, s, o, e, t);
    chk("rerr_err", e, 1'b1);
    chk("rerr_sum", s, 32'd0);
    chk("rerr_ar_beats", ar_n - ar0, 1);
    cfg_rresp = 2'b00;

    // Reset while waiting for the sum read data
    req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!bus.rready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("mid_rdata_reached", bus.rready, 1'b1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_arvalid", bus.arvalid, 1'b0);
    chk("mid_rst_rready", bus.rready, 1'b0);
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    rstn = 1'b1;
    @(posedge clk); #1;
    run_op(vecs[0].a, vecs[0].b, 0, lat, s, o, e, t);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_sum", s, vecs[0].sum);
    chk("post_rst_err", e, 1'b0);

`ifdef ADDSEQ_TIMEOUT_EN
    cfg_ar_stall = 1'b1;
    snap();
    run_op(32'd1, 32'd2, 0, lat, s, o, e, t);
    chk("tmo_arv_cycles", arv_n - arv0, 16);
    chk("tmo_latency", lat, 21);
    chk("tmo_err", e, 1'b1);
    chk("tmo_flag", t, 1'b1);
    chk("tmo_ar_beats", ar_n - ar0, 0);
    cfg_ar_stall = 1'b0;
`endif

    chk("wstrb_all_ones", bad_strb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
